// File: rtl/i2c_master_byte_if.sv
// Host command/response bundle for the byte-level I2C master.
// master: host side (issues cmds); slave: engine side (answers).
`timescale 1ns/1ps
interface i2c_master_byte_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       tx_ack;
  logic       rsp_valid;
  logic [7:0] rd_data;
  logic       ack_rcvd;
  logic       err;

  modport master (
    output cmd_valid, cmd, wr_data, tx_ack,
    input  cmd_ready, rsp_valid, rd_data, ack_rcvd, err
  );

  modport slave (
    input  cmd_valid, cmd, wr_data, tx_ack,
    output cmd_ready, rsp_valid, rd_data, ack_rcvd, err
  );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START/RSTART/WRITE/READ/STOP from divider ticks.
// Ports: clk/rst_n, clk_en/clk_en_half in, scl_en out, host if, scl_o/sda_o/sda_i, busy.
`timescale 1ns/1ps
module i2c_master_byte #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         clk_en_half,
  output logic         scl_en,
  output logic         busy,
  output logic         scl_o,
  output logic         sda_o,
  input  logic         sda_i,
  i2c_master_byte_if.slave host
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, START, RSTART, BITS, STOP, HOLD
  } state_t;

  state_t      state;
  logic [NS-1:0] sync_q;
  logic [1:0]  cmd_q;
  logic [7:0]  shreg;
  logic [3:0]  cnt;
  logic        pend;
  logic        phase;
  logic        tx_ack_q;
  logic        ready_q;
  logic        rsp_q;
  logic [7:0]  rd_q;
  logic        ack_q;
  logic        err_q;

  logic sda_s;
  logic ce;
  logic ch;
  logic accept;

  assign sda_s  = sync_q[NS-1];
  // end-of-period tick wins over a coincident mid-period tick
  assign ce     = clk_en & scl_en;
  assign ch     = clk_en_half & scl_en & ~clk_en;
  assign accept = host.cmd_valid & ready_q;

  assign host.cmd_ready = ready_q;
  assign host.rsp_valid = rsp_q;
  assign host.rd_data   = rd_q;
  assign host.ack_rcvd  = ack_q;
  assign host.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[NS-2:0], sda_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= C_START;
      shreg    <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      phase    <= 1'b0;
      tx_ack_q <= 1'b1;
      ready_q  <= 1'b1;
      rsp_q    <= 1'b0;
      rd_q     <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      scl_en   <= 1'b0;
      busy     <= 1'b0;
      scl_o    <= 1'b1;
      sda_o    <= 1'b1;
    end else begin
      rsp_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (host.cmd == C_START) begin
              state   <= START;
              scl_en  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              rsp_q <= 1'b1;
              err_q <= 1'b1;
            end
          end
        end
        START: begin
          // never drop SCL before SDA has fallen
          if (ce && !sda_o) begin
            scl_o   <= 1'b0;
            busy    <= 1'b1;
            rsp_q   <= 1'b1;
            ready_q <= 1'b1;
            state   <= HOLD;
          end else if (ch) begin
            sda_o <= 1'b0;
          end
        end
        HOLD: begin
          if (accept) begin
            cmd_q    <= host.cmd;
            shreg    <= host.wr_data;
            tx_ack_q <= host.tx_ack;
            pend     <= 1'b1;
            ready_q  <= 1'b0;
          end else if (pend && ce) begin
            pend  <= 1'b0;
            cnt   <= '0;
            phase <= 1'b0;
            unique case (cmd_q)
              C_START: begin
                state <= RSTART;
                sda_o <= 1'b1;
              end
              C_WRITE: begin
                state <= BITS;
                sda_o <= shreg[7];
              end
              C_READ: begin
                state <= BITS;
                sda_o <= 1'b1;
              end
              default: begin
                state <= STOP;
                sda_o <= 1'b0;
              end
            endcase
          end
        end
        RSTART: begin
          if (ce) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              scl_o   <= 1'b0;
              rsp_q   <= 1'b1;
              ready_q <= 1'b1;
              state   <= HOLD;
            end
          end else if (ch) begin
            if (!phase) scl_o <= 1'b1;
            else        sda_o <= 1'b0;
          end
        end
        BITS: begin
          if (ce) begin
            scl_o <= 1'b0;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd8) begin
              rsp_q   <= 1'b1;
              ready_q <= 1'b1;
              state   <= HOLD;
              if (cmd_q == C_WRITE) ack_q <= sda_s;
              else                  rd_q  <= shreg;
            end else if (cmd_q == C_WRITE) begin
              shreg <= {shreg[6:0], 1'b0};
              sda_o <= (cnt == 4'd7) ? 1'b1 : shreg[6];
            end else begin
              shreg <= {shreg[6:0], sda_s};
              sda_o <= (cnt == 4'd7) ? tx_ack_q : 1'b1;
            end
          end else if (ch) begin
            scl_o <= 1'b1;
          end
        end
        STOP: begin
          if (ce) begin
            sda_o   <= 1'b1;
            busy    <= 1'b0;
            scl_en  <= 1'b0;
            rsp_q   <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else if (ch) begin
            scl_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Randomized bench for i2c_master_byte with divider, slave and bus monitor.
// Bus-level events are decoded and compared against per-command expectations.
`timescale 1ns/1ps
module tb_i2c_master_byte;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en, clk_en_half, scl_en, busy, scl_o, sda_o, sda_i;

  always #50 clk = ~clk;

  i2c_master_byte_if bus ();

  i2c_master_byte #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .clk_en_half (clk_en_half),
    .scl_en      (scl_en),
    .busy        (busy),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .sda_i       (sda_i),
    .host        (bus)
  );

  // divider: 51-cycle period, fast start gives a half tick 3 cycles in
  int dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dcnt <= 22;
    else if (!scl_en) dcnt <= 22;
    else              dcnt <= (dcnt == 50) ? 0 : dcnt + 1;
  end
  assign clk_en      = scl_en && (dcnt == 50);
  assign clk_en_half = scl_en && (dcnt == 25);

  // slave: drives pattern bit (MSB first) for the period after each SCL fall
  logic [8:0] slave_pat = '1;
  int fall_base = 0;
  int fall_cnt = 0;
  int sidx;
  logic slave_bit;
  always_comb begin
    sidx = fall_cnt - fall_base;
    slave_bit = 1'b1;
    if (sidx >= 0 && sidx <= 8) slave_bit = slave_pat[8-sidx];
  end
  assign sda_i = sda_o & slave_bit;

  // bus monitor
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;
  int start_cnt = 0;
  int stop_cnt = 0;
  int rsp_cnt = 0;
  bit q_bus[$];
  bit q_mst[$];
  logic [7:0] l_rd = '0;
  logic l_ack = 1'b0;
  logic l_err = 1'b0;

  always @(negedge clk) begin
    p_scl <= scl_o;
    p_sda <= sda_i;
    if (p_scl && scl_o && p_sda && !sda_i) start_cnt <= start_cnt + 1;
    if (p_scl && scl_o && !p_sda && sda_i) stop_cnt <= stop_cnt + 1;
    if (!p_scl && scl_o) begin
      q_bus.push_back(sda_i);
      q_mst.push_back(sda_o);
    end
    if (p_scl && !scl_o) fall_cnt <= fall_cnt + 1;
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      l_rd    <= bus.rd_data;
      l_ack   <= bus.ack_rcvd;
      l_err   <= bus.err;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int bus_base, st_base, sp_base, rsp_base;
  logic en_after;

  function automatic logic [8:0] bits9(input bit mst, input int base);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) begin
      if (mst) v = {v[7:0], (base + i < q_mst.size()) ? q_mst[base+i] : 1'b0};
      else     v = {v[7:0], (base + i < q_bus.size()) ? q_bus[base+i] : 1'b0};
    end
    return v;
  endfunction

  task automatic issue(input logic [1:0] c, input logic [7:0] wd,
                       input logic ta, input logic [8:0] pat);
    int n = 0;
    slave_pat = pat;
    fall_base = fall_cnt;
    bus_base  = q_bus.size();
    st_base   = start_cnt;
    sp_base   = stop_cnt;
    rsp_base  = rsp_cnt;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.wr_data   = wd;
    bus.tx_ack    = ta;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    en_after      = scl_en;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_cnt == rsp_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, {31'd0, rsp_cnt != rsp_base}, 1);
    repeat (4) @(negedge clk);
    chk({tag, "_rsp_once"}, rsp_cnt - rsp_base, 1);
  endtask

  task automatic do_start();
    issue(2'b00, 8'h00, 1'b1, 9'h1FF);
    chk("start_scl_en", {31'd0, en_after}, 1);
    wait_rsp("start");
    chk("start_sda_fall", start_cnt - st_base, 1);
    chk("start_nostop", stop_cnt - sp_base, 0);
    chk("start_bus", {28'd0, busy, scl_o, sda_o, l_err}, 32'b1000);
  endtask

  task automatic do_rstart();
    issue(2'b00, 8'h00, 1'b1, 9'h1FF);
    wait_rsp("rs");
    chk("rs_start", start_cnt - st_base, 1);
    chk("rs_nostop", stop_cnt - sp_base, 0);
    chk("rs_pulses", q_bus.size() - bus_base, 1);
    chk("rs_sda_hi", {31'd0, q_bus[bus_base]}, 1);
    chk("rs_busy", {30'd0, busy, l_err}, 32'b10);
  endtask

  task automatic do_write(input logic [7:0] wd, input logic ack);
    issue(2'b01, wd, 1'b0, {8'hFF, ack});
    wait_rsp("wr");
    chk("wr_pulses", q_bus.size() - bus_base, 9);
    chk("wr_bus", {23'd0, bits9(1'b0, bus_base)}, {23'd0, wd, ack});
    chk("wr_ack", {31'd0, l_ack}, {31'd0, ack});
    chk("wr_ss", (start_cnt - st_base) + (stop_cnt - sp_base), 0);
    chk("wr_busy", {30'd0, busy, l_err}, 32'b10);
  endtask

  task automatic do_read(input logic [7:0] byt, input logic ta);
    issue(2'b10, 8'h00, ta, {byt, 1'b1});
    wait_rsp("rd");
    chk("rd_pulses", q_bus.size() - bus_base, 9);
    chk("rd_data", {24'd0, l_rd}, {24'd0, byt});
    chk("rd_bus", {23'd0, bits9(1'b0, bus_base)}, {23'd0, byt, ta});
    chk("rd_mst", {23'd0, bits9(1'b1, bus_base)}, {23'd0, 8'hFF, ta});
    chk("rd_ss", (start_cnt - st_base) + (stop_cnt - sp_base), 0);
    chk("rd_err", {31'd0, l_err}, 0);
  endtask

  task automatic do_stop();
    issue(2'b11, 8'h00, 1'b1, 9'h1FF);
    wait_rsp("stop");
    chk("stop_sda_rise", stop_cnt - sp_base, 1);
    chk("stop_nostart", start_cnt - st_base, 0);
    chk("stop_idle",
        {26'd0, scl_en, busy, bus.cmd_ready, scl_o, sda_o, l_err},
        32'b001110);
  endtask

  task automatic do_illegal(input logic [1:0] c);
    issue(c, 8'h5A, 1'b0, 9'h1FF);
    wait_rsp("ill");
    chk("ill_err", {31'd0, l_err}, 1);
    chk("ill_bus", {29'd0, scl_en, scl_o, sda_o}, 32'b011);
    chk("ill_pulses", q_bus.size() - bus_base, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_outs"},
        {24'd0, scl_o, sda_o, scl_en, bus.cmd_ready, busy,
         bus.rsp_valid, bus.ack_rcvd, bus.err},
        32'b1101_0000);
    chk({tag, "_rd"}, {24'd0, bus.rd_data}, 0);
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.wr_data   = 8'h00;
    bus.tx_ack    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_illegal(2'b01);
    do_start();
    do_write(8'hA5, 1'b0);
    do_read(8'h3C, 1'b1);
    do_rstart();
    do_write(8'h00, 1'b1);
    do_read(8'hFF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      do_write(8'($urandom), 1'($urandom));
      else if (r < 8) do_read(8'($urandom), 1'($urandom));
      else            do_rstart();
    end
    do_stop();
    do_illegal(2'b10);
    do_illegal(2'b11);

    do_start();
    issue(2'b01, 8'hC3, 1'b0, 9'h1FE);
    n = 0;
    while (fall_cnt - fall_base < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_bit4", {31'd0, fall_cnt - fall_base >= 3}, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_rsp", rsp_cnt - rsp_base, 0);
    do_start();
    do_write(8'h96, 1'b0);
    do_stop();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Byte-level I2C master engine. It sits directly downstream of the team's I2C clock-enable divider.
- It drives the divider's scl_en and consumes its clk_en (end-of-bit-period tick) and clk_en_half (mid-period tick).
- From those ticks it generates SCL/SDA for START, repeated START, WRITE byte, READ byte and STOP, under a valid/ready command interface from the host controller.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising sda_i before use (minimum 2).

Ports:
- clk  in  1  system clock (10 MHz)
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  divider end-of-period tick, one cycle wide
- clk_en_half  in  1  divider mid-period tick, one cycle wide
- scl_en  out  1  enable to divider
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd  in  2  00 START, 01 WRITE, 10 READ, 11 STOP
- wr_data  in  8  byte for WRITE, captured at accept
- tx_ack  in  1  bit master sends after READ (0=ACK, 1=NACK), captured at accept
- rsp_valid  out  1  one-cycle pulse when a command completes
- rd_data  out  8  byte received by READ, valid with rsp_valid
- ack_rcvd  out  1  slave ack bit from WRITE (0=ACK), valid with rsp_valid
- err  out  1  illegal command, valid with rsp_valid
- busy  out  1  bus owned (between START and end of STOP)
- scl_o  out  1  SCL level
- sda_o  out  1  SDA open-drain control (0 = drive low, 1 = release)
- sda_i  in  1  SDA pad input

Behaviour:
Reset values:
- scl_o=1, sda_o=1, scl_en=0, cmd_ready=1, busy=0, rsp_valid=0, rd_data=0, ack_rcvd=0, err=0.
- Reset mid-operation aborts immediately to IDLE with these values; no STOP is generated.

Tick handling:
- Ticks are acted on only when scl_en=1; ticks arriving while scl_en=0 are ignored.
- If clk_en and clk_en_half are both high in the same cycle, clk_en takes priority.
- A bit period runs from one clk_en to the next:
  - SDA changes only while SCL is low.
  - SCL rises on the cycle after clk_en_half.
  - SDA is sampled (synchronised value) in the cycle clk_en is high.
  - SCL falls on the cycle after clk_en.

States: IDLE, START, RSTART, BITS, STOP, HOLD.

IDLE:
- cmd_ready=1.
- START → state START; scl_en=1 in the next cycle.
- WRITE, READ or STOP → accepted, no bus activity; rsp_valid=1 with err=1 on the next cycle.

START:
- The divider's fast start supplies clk_en_half within a few cycles.
- On clk_en_half: sda_o=0 (SCL still 1).
- On clk_en: scl_o=0, busy=1, rsp_valid, go to HOLD.

HOLD:
- SCL low, SDA held at its last value; cmd_ready=1; scl_en stays 1.
- Divider ticks continue but are ignored until a command is accepted.
- Command execution starts at the next clk_en after accept.

RSTART (START accepted in HOLD):
- Period 1: sda_o=1, SCL rises at clk_en_half, stays high through clk_en.
- Period 2: sda_o=0 at clk_en_half, scl_o=0 at clk_en, rsp_valid, back to HOLD.

BITS: 9 periods.
- WRITE:
  - Periods 1–8 drive wr_data MSB first.
  - Period 9 sets sda_o=1; the sample taken there is stored into ack_rcvd.
- READ:
  - Periods 1–8: sda_o=1; samples shift MSB first into rd_data.
  - Period 9 drives tx_ack.
- rsp_valid pulses on the cycle after the 9th clk_en; then HOLD.

STOP:
- sda_o=0 with SCL low, then SCL rises at clk_en_half.
- At the next clk_en: sda_o=1, scl_o stays 1, busy=0, scl_en=0, rsp_valid, IDLE.

General rules:
- cmd_ready=0 in START, RSTART, BITS and STOP.
- rsp_valid is exactly one cycle per accepted command.
- err=0 for all legal commands.
- Clock stretching and arbitration are not supported; sda_i is used only for data and ack sampling.

Test Plan:
- Divider defaults (51 clk cycles per period). START from IDLE → scl_en rises 1 cycle after accept; SDA falls while SCL=1; SCL falls at the first clk_en; rsp_valid 1 cycle; busy=1; err=0.
- WRITE 0xA5 with the slave model pulling SDA low in period 9 → SDA bits 1,0,1,0,0,1,0,1 stable across each SCL high phase; ack_rcvd=0; rsp_valid after 9 SCL pulses.
- READ with slave driving 0x3C, tx_ack=1 → rd_data=0x3C; sda_o=1 in period 9; rsp_valid once.
- START during HOLD → SDA returns high, SCL rises, then SDA falls while SCL=1 (repeated START); busy stays 1.
- STOP → SDA rises while SCL=1; scl_en=0, busy=0, cmd_ready=1. WRITE issued in IDLE → rsp_valid with err=1, scl_o and sda_o stay 1.
- rst_n asserted mid-WRITE (bit 4) → all outputs at reset values within the same cycle; a subsequent START runs normally.
